// File: rtl/core_lsu_mem_bridge_pkg.sv
// Shared definitions for the LSU-to-memory bridge: func3 codes, access sizes and
// the pending-load tag that travels alongside each outstanding load.
package core_lsu_mem_bridge_pkg;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  localparam int MEM_BE_W = 4;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } acc_size_e;

  typedef struct packed {
    logic [2:0] rwtyp;
    logic [1:0] off;
  } pend_t;

  // Reserved func3 encodings behave as full-word accesses.
  function automatic acc_size_e size_of(input logic [2:0] func3);
    case (func3)
      LSU_B, LSU_BU: return SZ_BYTE;
      LSU_H, LSU_HU: return SZ_HALF;
      default:       return SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/core_lsu_mem_bridge_fifo.sv
// core_sync_fifo: small first-word-fall-through FIFO; DEPTH must be a power of 2
// so the pointers wrap naturally. Simultaneous push/pop leaves occupancy unchanged.
module core_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  // Storage carries no reset; reset only empties the FIFO via pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/core_lsu_mem_bridge.sv
// LSU bus to word-wide data memory bridge: store lane encoding, in-order load tracking
// with credit flow control, and load alignment/extension. Optional: LSU_BRIDGE_MISALIGN_CHK_EN.
module core_lsu_mem_bridge
  import core_lsu_mem_bridge_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                lsu_req_vld,
  input  logic                lsu_req_wen,
  input  logic [2:0]          lsu_req_rwtyp,
  input  logic [ADDR_W-1:0]   lsu_req_addr,
  input  logic [31:0]         lsu_req_wdata,
  output logic                lsu_req_rdy,
  output logic                lsu_resp_vld,
  output logic [31:0]         lsu_resp_rdata,
  input  logic                lsu_resp_rdy,
  output logic                mem_req,
  output logic                mem_we,
  output logic [MEM_BE_W-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [31:0]         mem_wdata,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [31:0]         mem_rdata,
  output logic                misalign_err,
  output logic [ADDR_W-1:0]   misalign_addr
);

  localparam int CRD_W = $clog2(DEPTH + 1);

  logic [CRD_W-1:0] crd;
  logic             has_crd;
  logic             load_gnt;
  logic             resp_fire;
  logic [1:0]       req_off;
  acc_size_e        req_size;
  pend_t            pend_in;
  pend_t            pend_head;
  logic             pend_empty;
  logic             pend_full;
  logic [31:0]      resp_head;
  logic             resp_empty;
  logic             resp_full;
  acc_size_e        resp_size;
  logic             resp_signed;
  logic [31:0]      byte_word;
  logic [31:0]      half_word;
  logic [31:0]      ext_data;

  assign has_crd     = (crd < CRD_W'(DEPTH));
  assign mem_req     = lsu_req_vld & (lsu_req_wen | has_crd);
  assign lsu_req_rdy = mem_gnt & (lsu_req_wen | has_crd);
  assign mem_we      = lsu_req_vld & lsu_req_wen;
  assign mem_addr    = lsu_req_vld ? {lsu_req_addr[ADDR_W-1:2], 2'b00} : '0;
  assign load_gnt    = mem_req & mem_gnt & ~mem_we;
  assign resp_fire   = lsu_resp_vld & lsu_resp_rdy;

  assign req_off  = lsu_req_addr[1:0];
  assign req_size = size_of(lsu_req_rwtyp);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      crd <= '0;
    end else begin
      case ({load_gnt, resp_fire})
        2'b10:   crd <= crd + 1'b1;
        2'b01:   crd <= crd - 1'b1;
        default: crd <= crd;
      endcase
    end
  end

  always_comb begin
    mem_be    = '0;
    mem_wdata = '0;
    if (lsu_req_vld) begin
      if (!lsu_req_wen) begin
        mem_be = 4'b1111;
      end else begin
        case (req_size)
          SZ_BYTE: begin
            mem_be    = 4'b0001 << req_off;
            mem_wdata = {4{lsu_req_wdata[7:0]}};
          end
          SZ_HALF: begin
            mem_be    = 4'b0011 << {req_off[1], 1'b0};
            mem_wdata = {2{lsu_req_wdata[15:0]}};
          end
          default: begin
            mem_be    = 4'b1111;
            mem_wdata = lsu_req_wdata;
          end
        endcase
      end
    end
  end

  assign pend_in = '{rwtyp: lsu_req_rwtyp, off: req_off};

  core_sync_fifo #(.WIDTH($bits(pend_t)), .DEPTH(DEPTH)) u_pend_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (load_gnt),
    .wdata (pend_in),
    .pop   (resp_fire & ~pend_empty),
    .rdata (pend_head),
    .empty (pend_empty),
    .full  (pend_full)
  );

  // Returned words land here because mem_rvalid cannot be back-pressured.
  core_sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_resp_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (mem_rvalid),
    .wdata (mem_rdata),
    .pop   (resp_fire),
    .rdata (resp_head),
    .empty (resp_empty),
    .full  (resp_full)
  );

  assign lsu_resp_vld = ~resp_empty;

  assign resp_size   = size_of(pend_head.rwtyp);
  assign resp_signed = ~pend_head.rwtyp[2];
  assign byte_word   = resp_head >> {pend_head.off, 3'b000};
  assign half_word   = resp_head >> {pend_head.off[1], 4'b0000};

  always_comb begin
    case (resp_size)
      SZ_BYTE: ext_data = {{24{resp_signed & byte_word[7]}}, byte_word[7:0]};
      SZ_HALF: ext_data = {{16{resp_signed & half_word[15]}}, half_word[15:0]};
      default: ext_data = resp_head;
    endcase
  end

  assign lsu_resp_rdata = lsu_resp_vld ? ext_data : '0;

`ifdef LSU_BRIDGE_MISALIGN_CHK_EN
  logic              req_misaligned;
  logic              misalign_err_reg;
  logic [ADDR_W-1:0] misalign_addr_reg;

  always_comb begin
    case (req_size)
      SZ_HALF: req_misaligned = req_off[0];
      SZ_WORD: req_misaligned = |req_off;
      default: req_misaligned = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      misalign_err_reg  <= 1'b0;
      misalign_addr_reg <= '0;
    end else begin
      misalign_err_reg <= lsu_req_vld & lsu_req_rdy & req_misaligned;
      if (lsu_req_vld & lsu_req_rdy & req_misaligned)
        misalign_addr_reg <= lsu_req_addr;
    end
  end

  assign misalign_err  = misalign_err_reg;
  assign misalign_addr = misalign_addr_reg;
`else
  assign misalign_err  = 1'b0;
  assign misalign_addr = '0;
`endif

  resp_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
    !(mem_rvalid && resp_full));
  pend_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
    !(load_gnt && pend_full && !resp_fire));

endmodule

// File: tb/tb_core_lsu_mem_bridge.sv
// Self-checking bench for core_lsu_mem_bridge; expected load data is queued when a
// load is granted and compared as the LSU takes each response.
module tb_core_lsu_mem_bridge;
  import core_lsu_mem_bridge_pkg::*;

  localparam int DEPTH  = 2;
  localparam int ADDR_W = 32;

  logic              clk;
  logic              rstn;
  logic              lsu_req_vld;
  logic              lsu_req_wen;
  logic [2:0]        lsu_req_rwtyp;
  logic [ADDR_W-1:0] lsu_req_addr;
  logic [31:0]       lsu_req_wdata;
  logic              lsu_req_rdy;
  logic              lsu_resp_vld;
  logic [31:0]       lsu_resp_rdata;
  logic              lsu_resp_rdy;
  logic              mem_req;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;
  logic              misalign_err;
  logic [ADDR_W-1:0] misalign_addr;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  core_lsu_mem_bridge #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .lsu_req_vld    (lsu_req_vld),
    .lsu_req_wen    (lsu_req_wen),
    .lsu_req_rwtyp  (lsu_req_rwtyp),
    .lsu_req_addr   (lsu_req_addr),
    .lsu_req_wdata  (lsu_req_wdata),
    .lsu_req_rdy    (lsu_req_rdy),
    .lsu_resp_vld   (lsu_resp_vld),
    .lsu_resp_rdata (lsu_resp_rdata),
    .lsu_resp_rdy   (lsu_resp_rdy),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_be         (mem_be),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_gnt        (mem_gnt),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .misalign_err   (misalign_err),
    .misalign_addr  (misalign_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (checks %0d)", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Grants one load; caller pushes the expected response.
  task automatic issue_load(input logic [2:0] typ, input logic [31:0] addr);
    lsu_req_vld   = 1'b1;
    lsu_req_wen   = 1'b0;
    lsu_req_rwtyp = typ;
    lsu_req_addr  = addr;
    mem_gnt       = 1'b1;
    tick();
    lsu_req_vld = 1'b0;
    mem_gnt     = 1'b0;
  endtask

  task automatic return_word(input logic [31:0] d);
    mem_rvalid = 1'b1;
    mem_rdata  = d;
    tick();
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if ({lsu_resp_vld, mem_req, mem_we, lsu_req_rdy, misalign_err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 00000", {lsu_resp_vld, mem_req, mem_we, lsu_req_rdy, misalign_err});
    end
    tick();
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if ({mem_be, mem_addr, mem_wdata, lsu_resp_rdata, misalign_addr} !== '0) begin
      errors++;
      $display("FAIL reset_data: be %b addr %h wdata %h rdata %h maddr %h want all 0",
               mem_be, mem_addr, mem_wdata, lsu_resp_rdata, misalign_addr);
    end
    $display("reset released");
    tick();
  endtask

  task automatic test_store();
    logic [2:0]  typ  [3] = '{LSU_B, LSU_H, LSU_W};
    logic [31:0] addr [3] = '{32'h1003, 32'h1002, 32'h1004};
    logic [31:0] wd   [3] = '{32'h0000_00AB, 32'h0000_1234, 32'hDEAD_BEEF};
    logic [3:0]  ebe  [3] = '{4'b1000, 4'b1100, 4'b1111};
    logic [31:0] ewd  [3] = '{32'hABAB_ABAB, 32'h1234_1234, 32'hDEAD_BEEF};
    logic [31:0] eadr [3] = '{32'h1000, 32'h1000, 32'h1004};
    for (int i = 0; i < 3; i++) begin
      lsu_req_vld   = 1'b1;
      lsu_req_wen   = 1'b1;
      lsu_req_rwtyp = typ[i];
      lsu_req_addr  = addr[i];
      lsu_req_wdata = wd[i];
      mem_gnt       = 1'b1;
      @(negedge clk);
      checks++;
      if ({mem_req, mem_we, lsu_req_rdy, mem_be, mem_addr, mem_wdata} !==
          {3'b111, ebe[i], eadr[i], ewd[i]}) begin
        errors++;
        $display("FAIL store_%0d: req/we/rdy %b be %b addr %h wdata %h want 111 %b %h %h",
                 i, {mem_req, mem_we, lsu_req_rdy}, mem_be, mem_addr, mem_wdata, ebe[i], eadr[i], ewd[i]);
      end
      $display("store typ %b addr %h be %b wdata %h", typ[i], addr[i], mem_be, mem_wdata);
      tick();
    end
    lsu_req_vld = 1'b0;
    lsu_req_wen = 1'b0;
    mem_gnt     = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if (lsu_resp_vld !== 1'b0) begin
      errors++;
      $display("FAIL store_no_resp: lsu_resp_vld %b want 0", lsu_resp_vld);
    end
    tick();
  endtask

  task automatic test_load_extract();
    logic [2:0]  typ  [6] = '{LSU_B, LSU_BU, LSU_H, LSU_HU, LSU_W, LSU_B};
    logic [31:0] addr [6] = '{32'h1002, 32'h1002, 32'h1002, 32'h1000, 32'h1000, 32'h1001};
    logic [31:0] rd   [6] = '{32'h1280FF00, 32'h1280FF00, 32'h80010000, 32'h1234ABCD,
                              32'h1234ABCD, 32'h00007F00};
    logic [31:0] ex   [6] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h0000ABCD,
                              32'h1234ABCD, 32'h0000007F};
    logic [31:0] e;
    for (int i = 0; i < 6; i++) begin
      issue_load(typ[i], addr[i]);
      exp_q.push_back(ex[i]);
      return_word(rd[i]);
      lsu_resp_rdy = 1'b1;
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (lsu_resp_vld !== 1'b1 || lsu_resp_rdata !== e) begin
        errors++;
        $display("FAIL load_%0d: vld %b data %h want 1 %h", i, lsu_resp_vld, lsu_resp_rdata, e);
      end
      $display("load typ %b addr %h raw %h resp %h", typ[i], addr[i], rd[i], lsu_resp_rdata);
      tick();
      lsu_resp_rdy = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (lsu_resp_vld !== 1'b0) begin
      errors++;
      $display("FAIL load_drained: lsu_resp_vld %b want 0", lsu_resp_vld);
    end
    tick();
  endtask

  task automatic test_credit_block();
    logic [31:0] e;
    issue_load(LSU_W, 32'h10);
    exp_q.push_back(32'hA000_0001);
    issue_load(LSU_W, 32'h14);
    exp_q.push_back(32'hA000_0002);
    lsu_req_vld   = 1'b1;
    lsu_req_wen   = 1'b0;
    lsu_req_rwtyp = LSU_W;
    lsu_req_addr  = 32'h18;
    mem_gnt       = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b0 || lsu_req_rdy !== 1'b0) begin
      errors++;
      $display("FAIL credit_block: mem_req %b rdy %b want 0 0", mem_req, lsu_req_rdy);
    end
    tick();
    return_word(32'hA000_0001);
    return_word(32'hA000_0002);
    lsu_resp_rdy = 1'b1;
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (mem_req !== 1'b0 || lsu_resp_vld !== 1'b1 || lsu_resp_rdata !== e) begin
      errors++;
      $display("FAIL credit_first: mem_req %b vld %b data %h want 0 1 %h", mem_req, lsu_resp_vld, lsu_resp_rdata, e);
    end
    $display("load addr 00000010 resp %h", lsu_resp_rdata);
    tick();
    lsu_resp_rdy = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || lsu_req_rdy !== 1'b1) begin
      errors++;
      $display("FAIL credit_release: mem_req %b rdy %b want 1 1", mem_req, lsu_req_rdy);
    end
    exp_q.push_back(32'hA000_0003);
    tick();
    lsu_req_vld = 1'b0;
    mem_gnt     = 1'b0;
    return_word(32'hA000_0003);
    lsu_resp_rdy = 1'b1;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (lsu_resp_vld !== 1'b1 || lsu_resp_rdata !== e) begin
        errors++;
        $display("FAIL credit_drain: vld %b data %h want 1 %h", lsu_resp_vld, lsu_resp_rdata, e);
      end
      $display("load resp %h", lsu_resp_rdata);
      tick();
    end
    lsu_resp_rdy = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] e;
    issue_load(LSU_W, 32'h20);
    exp_q.push_back(32'hB000_000A);
    return_word(32'hB000_000A);
    // Grant and pop in the same cycle: credit must stay at one.
    lsu_req_vld   = 1'b1;
    lsu_req_wen   = 1'b0;
    lsu_req_rwtyp = LSU_W;
    lsu_req_addr  = 32'h24;
    mem_gnt       = 1'b1;
    lsu_resp_rdy  = 1'b1;
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (mem_req !== 1'b1 || lsu_resp_vld !== 1'b1 || lsu_resp_rdata !== e) begin
      errors++;
      $display("FAIL b2b_overlap: mem_req %b vld %b data %h want 1 1 %h", mem_req, lsu_resp_vld, lsu_resp_rdata, e);
    end
    $display("load addr 00000020 resp %h (with grant of 00000024)", lsu_resp_rdata);
    exp_q.push_back(32'hB000_000B);
    tick();
    lsu_resp_rdy = 1'b0;
    lsu_req_addr = 32'h28;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1) begin
      errors++;
      $display("FAIL b2b_crd_kept: mem_req %b want 1", mem_req);
    end
    exp_q.push_back(32'hB000_000C);
    tick();
    lsu_req_addr = 32'h2C;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL b2b_crd_full: mem_req %b want 0", mem_req);
    end
    tick();
    lsu_req_vld = 1'b0;
    mem_gnt     = 1'b0;
    return_word(32'hB000_000B);
    return_word(32'hB000_000C);
    repeat (2) tick();
    lsu_resp_rdy = 1'b1;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (lsu_resp_vld !== 1'b1 || lsu_resp_rdata !== e) begin
        errors++;
        $display("FAIL b2b_order: vld %b data %h want 1 %h", lsu_resp_vld, lsu_resp_rdata, e);
      end
      $display("load resp %h", lsu_resp_rdata);
      tick();
    end
    lsu_resp_rdy = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] e;
    issue_load(LSU_W, 32'h30);
    issue_load(LSU_W, 32'h34);
    return_word(32'hC000_0000);
    rstn = 1'b0;
    #1;
    checks++;
    if (lsu_resp_vld !== 1'b0 || lsu_resp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_resp: vld %b data %h want 0 0", lsu_resp_vld, lsu_resp_rdata);
    end
    tick();
    rstn = 1'b1;
    $display("reset mid-operation");
    for (int i = 0; i < 3; i++) begin
      lsu_req_vld   = 1'b1;
      lsu_req_wen   = 1'b0;
      lsu_req_rwtyp = LSU_W;
      lsu_req_addr  = 32'h40 + 32'(4 * i);
      mem_gnt       = 1'b1;
      @(negedge clk);
      checks++;
      if (mem_req !== (i < 2)) begin
        errors++;
        $display("FAIL reset_mid_crd_%0d: mem_req %b want %b", i, mem_req, (i < 2));
      end
      if (i < 2) exp_q.push_back(32'hD000_0000 + 32'(i));
      tick();
    end
    lsu_req_vld = 1'b0;
    mem_gnt     = 1'b0;
    return_word(32'hD000_0000);
    return_word(32'hD000_0001);
    lsu_resp_rdy = 1'b1;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (lsu_resp_vld !== 1'b1 || lsu_resp_rdata !== e) begin
        errors++;
        $display("FAIL reset_mid_data: vld %b data %h want 1 %h", lsu_resp_vld, lsu_resp_rdata, e);
      end
      $display("load resp %h", lsu_resp_rdata);
      tick();
    end
    lsu_resp_rdy = 1'b0;
  endtask

  task automatic test_misalign();
    logic [31:0] e;
    logic        exp_err;
    logic [31:0] exp_addr;
`ifdef LSU_BRIDGE_MISALIGN_CHK_EN
    exp_err  = 1'b1;
    exp_addr = 32'h2001;
`else
    exp_err  = 1'b0;
    exp_addr = 32'h0;
`endif
    lsu_req_vld   = 1'b1;
    lsu_req_wen   = 1'b0;
    lsu_req_rwtyp = LSU_W;
    lsu_req_addr  = 32'h2001;
    mem_gnt       = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_addr !== 32'h2000 || misalign_err !== 1'b0) begin
      errors++;
      $display("FAIL misalign_accept: addr %h err %b want 00002000 0", mem_addr, misalign_err);
    end
    exp_q.push_back(32'hE1E2_E3E4);
    tick();
    lsu_req_vld = 1'b0;
    mem_gnt     = 1'b0;
    @(negedge clk);
    checks++;
    if (misalign_err !== exp_err || misalign_addr !== exp_addr) begin
      errors++;
      $display("FAIL misalign_pulse: err %b addr %h want %b %h", misalign_err, misalign_addr, exp_err, exp_addr);
    end
    $display("misaligned LW 00002001 err %b addr %h", misalign_err, misalign_addr);
    tick();
    @(negedge clk);
    checks++;
    if (misalign_err !== 1'b0 || misalign_addr !== exp_addr) begin
      errors++;
      $display("FAIL misalign_hold: err %b addr %h want 0 %h", misalign_err, misalign_addr, exp_addr);
    end
    tick();
    return_word(32'hE1E2_E3E4);
    lsu_resp_rdy = 1'b1;
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (lsu_resp_vld !== 1'b1 || lsu_resp_rdata !== e) begin
      errors++;
      $display("FAIL misalign_data: vld %b data %h want 1 %h", lsu_resp_vld, lsu_resp_rdata, e);
    end
    tick();
    lsu_resp_rdy = 1'b0;
  endtask

  initial begin
    rstn          = 1'b0;
    lsu_req_vld   = 1'b0;
    lsu_req_wen   = 1'b0;
    lsu_req_rwtyp = '0;
    lsu_req_addr  = '0;
    lsu_req_wdata = '0;
    lsu_resp_rdy  = 1'b0;
    mem_gnt       = 1'b0;
    mem_rvalid    = 1'b0;
    mem_rdata     = '0;

    test_reset();
    test_store();
    test_load_extract();
    test_credit_block();
    test_back_to_back();
    test_reset_mid();
    test_misalign();

    @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || lsu_resp_vld !== 1'b0) begin
      errors++;
      $display("FAIL final_idle: queued %0d vld %b want 0 0", exp_q.size(), lsu_resp_vld);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
